uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing one `uart` transmitter between N byte-stream requesters.
- Accepts bytes on per-requester valid/ready ports and presents them on the UART's `tx_data` port.
- Drives the UART `start_tx` with a hold-until-accepted handshake, because the UART samples `start_tx` on its divided baud clock.
- Supports multi-byte packets: a requester holds the grant until it presents `last`.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT, 1024, clk cycles allowed in LAUNCH or LOCKED before abort (≥4).

Ports:
- clk  in  1  system clock; same clock as the UART's `clk` port.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  8*N_REQ  bytes; requester i uses bits [8i+7:8i].
- req_last  in  N_REQ  byte is the last of its packet.
- req_ready  out  N_REQ  one-hot accept pulse, combinational.
- uart_tx_data  out  8  connects to UART `tx_data`.
- uart_start_tx  out  1  connects to UART `start_tx`; registered.
- uart_tx_ready  in  1  from UART `tx_ready`; asynchronous to clk edges.
- grant_id  out  IDW  current/last granted requester; IDW = max(1, $clog2(N_REQ)).
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; all outputs 0, including uart_tx_data and grant_id.
  - Round-robin pointer = 0; lock cleared; synchroniser flops = 1.
- Synchroniser: uart_tx_ready passes through a 2-flop synchroniser giving `rdy_s`. All decisions use `rdy_s`, which lags by 2 cycles.
- Round-robin arbitration:
  - Search starts at the pointer, wrapping modulo N_REQ.
  - After a packet completes or aborts, pointer = winner+1 (wraps at N_REQ-1 → 0).
- IDLE:
  - If any req_valid, the winner w gets req_ready[w]=1 in the same cycle.
  - Same edge: capture data→uart_tx_data, last→last_q, grant_id←w; uart_start_tx←1; go LAUNCH.
- LAUNCH:
  - Hold uart_start_tx=1 and uart_tx_data stable.
  - When rdy_s=0: uart_start_tx←0; go BUSY.
  - After TIMEOUT cycles without rdy_s=0: uart_start_tx←0, pulse timeout_err, drop the byte, advance pointer, go IDLE.
- BUSY:
  - Wait for rdy_s=1. No timeout in this state; the UART frame length is bounded by the UART itself.
  - Then if last_q=1: advance pointer, go IDLE. Otherwise go LOCKED.
- LOCKED:
  - Only req_valid[grant_id] is considered; other requesters get req_ready=0.
  - On valid: req_ready pulse, capture, uart_start_tx←1, go LAUNCH.
  - After TIMEOUT idle cycles: pulse timeout_err, advance pointer, go IDLE. The packet is truncated.
- Minimum launch latency:
  - IDLE accept → uart_start_tx=1 on the next cycle.
  - UART accept, seen as rdy_s=0, takes 2 more cycles → start_tx deasserted on the following edge.
- Simultaneous events:
  - A requester dropping valid in the cycle it is granted is legal; ready is driven from the current valid, so no accept occurs.
  - A requester raising valid while another holds the lock waits; no starvation beyond one packet per other requester.
- Reset mid-frame: outputs return to reset values immediately; the in-flight UART frame is not tracked.
- Timeout counter: $clog2(TIMEOUT+1) bits, cleared on every state entry, saturating.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, LOCKED} sched_state_t;
  - localparam BYTE_W = 8.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; instantiated once.

Test Plan:
1. Single requester 0 sends 0xA5 (last=1), UART model drops tx_ready 5 cycles after start_tx → uart_tx_data=0xA5, start_tx high exactly until rdy_s=0, then IDLE; grant_id=0; pointer=1.
2. Req 0 and 2 both valid from reset, each one byte → order 0 then 2. Then req 0 and 2 again → order 0 then 2, proving rotation to 1→2→3→0 with wrap-around.
3. Req 1 sends 3-byte packet 0x11, 0x22, 0x33 (last on 0x33) while req 3 is valid throughout → all three req 1 bytes are sent before any req 3 byte; req_ready[3] stays 0 during LOCKED.
4. UART model never lowers tx_ready, TIMEOUT=8 → timeout_err pulses once 8 cycles into LAUNCH, start_tx falls, byte is dropped, next requester is served.
5. Req 0 sends a non-last byte then goes silent, TIMEOUT=8 → timeout_err pulses after 8 cycles in LOCKED and the lock is released.
6. Assert rst_n=0 asynchronously mid-LAUNCH → uart_start_tx, busy and req_ready go 0 without a clock edge; after release, requester 0 has priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    LOCKED = 2'd3
  } sched_state_t;

  // Next round-robin position after idx, wrapping from n-1 back to 0.
  function automatic logic [15:0] rr_next(input logic [15:0] idx, input logic [15:0] n);
    logic [15:0] inc;
    inc = idx + 16'd1;
    if (inc >= n) begin
      return 16'd0;
    end else begin
      return inc;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] index,
  output logic           any
);
  localparam int SW = IDW + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  // Scan N positions starting at ptr and latch the first active one.
  always_comb begin
    logic [SW-1:0]  sum;
    logic [IDW-1:0] pos;
    sum   = '0;
    pos   = '0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end else begin
        sum = sum;
      end
      pos = sum[IDW-1:0];
      if (enable && !any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte-stream
// requesters. start_tx is held until the UART (seen through a 2-flop
// synchroniser) drops tx_ready; packets keep the grant until their last byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 1024,
  localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]         uart_tx_data,
  output logic                      uart_start_tx,
  input  logic                      uart_tx_ready,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Registered state
  sched_state_t      state_r;
  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    grant_r;
  logic              last_r;
  logic [BYTE_W-1:0] data_r;
  logic              start_r;
  logic [CW-1:0]     cnt_r;
  logic              terr_r;
  logic              sync1_r;
  logic              rdy_s;

  // Next-state values
  sched_state_t      nxt_state_s;
  logic [IDW-1:0]    nxt_ptr_s;
  logic [IDW-1:0]    nxt_grant_s;
  logic              nxt_last_s;
  logic [BYTE_W-1:0] nxt_data_s;
  logic              nxt_start_s;
  logic [CW-1:0]     nxt_cnt_s;
  logic              nxt_terr_s;
  logic [N_REQ-1:0]  ready_s;

  logic [N_REQ-1:0]  arb_grant_s;
  logic [IDW-1:0]    arb_idx_s;
  logic              arb_any_s;
  logic              arb_en_s;
  logic [CW-1:0]     cnt_inc_s;
  logic              tmo_s;
  logic [IDW-1:0]    ptr_adv_s;
  logic [BYTE_W-1:0] req_byte_s [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_byte_s[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  assign arb_en_s  = (state_r == IDLE);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
  assign tmo_s     = (cnt_r >= CNT_LAST);
  assign ptr_adv_s = IDW'(rr_next(16'(grant_r), 16'(N_REQ)));

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .req    (req_valid),
    .ptr    (ptr_r),
    .enable (arb_en_s),
    .grant  (arb_grant_s),
    .index  (arb_idx_s),
    .any    (arb_any_s)
  );

  // Bring the UART's tx_ready into the clk domain; idles high like the UART.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      rdy_s   <= 1'b1;
    end else begin
      sync1_r <= uart_tx_ready;
      rdy_s   <= sync1_r;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      grant_r <= '0;
      last_r  <= 1'b0;
      data_r  <= '0;
      start_r <= 1'b0;
      cnt_r   <= '0;
      terr_r  <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      ptr_r   <= nxt_ptr_s;
      grant_r <= nxt_grant_s;
      last_r  <= nxt_last_s;
      data_r  <= nxt_data_s;
      start_r <= nxt_start_s;
      cnt_r   <= nxt_cnt_s;
      terr_r  <= nxt_terr_s;
    end
  end

  // Next-state logic: arbitration, launch handshake, packet lock, timeouts.
  always_comb begin
    nxt_state_s = state_r;
    nxt_ptr_s   = ptr_r;
    nxt_grant_s = grant_r;
    nxt_last_s  = last_r;
    nxt_data_s  = data_r;
    nxt_start_s = start_r;
    nxt_cnt_s   = cnt_r;
    nxt_terr_s  = 1'b0;
    ready_s     = '0;
    case (state_r)
      IDLE: begin
        if (arb_any_s) begin
          ready_s     = arb_grant_s;
          nxt_data_s  = req_byte_s[arb_idx_s];
          nxt_last_s  = req_last[arb_idx_s];
          nxt_grant_s = arb_idx_s;
          nxt_start_s = 1'b1;
          nxt_cnt_s   = '0;
          nxt_state_s = LAUNCH;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      LAUNCH: begin
        if (!rdy_s) begin
          nxt_start_s = 1'b0;
          nxt_cnt_s   = '0;
          nxt_state_s = BUSY;
        end else if (tmo_s) begin
          // UART never took the byte: drop it and move on.
          nxt_start_s = 1'b0;
          nxt_terr_s  = 1'b1;
          nxt_ptr_s   = ptr_adv_s;
          nxt_cnt_s   = '0;
          nxt_state_s = IDLE;
        end else begin
          nxt_cnt_s = cnt_inc_s;
        end
      end
      BUSY: begin
        if (rdy_s) begin
          nxt_cnt_s = '0;
          if (last_r) begin
            nxt_ptr_s   = ptr_adv_s;
            nxt_state_s = IDLE;
          end else begin
            nxt_state_s = LOCKED;
          end
        end else begin
          nxt_state_s = BUSY;
        end
      end
      LOCKED: begin
        if (req_valid[grant_r]) begin
          ready_s[grant_r] = 1'b1;
          nxt_data_s  = req_byte_s[grant_r];
          nxt_last_s  = req_last[grant_r];
          nxt_start_s = 1'b1;
          nxt_cnt_s   = '0;
          nxt_state_s = LAUNCH;
        end else if (tmo_s) begin
          // Packet owner went silent: truncate and release the lock.
          nxt_terr_s  = 1'b1;
          nxt_ptr_s   = ptr_adv_s;
          nxt_cnt_s   = '0;
          nxt_state_s = IDLE;
        end else begin
          nxt_cnt_s = cnt_inc_s;
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_start_s = 1'b0;
        nxt_cnt_s   = '0;
      end
    endcase
  end

  // Accept pulses are suppressed while reset is asserted.
  assign req_ready     = rst_n ? ready_s : '0;
  assign uart_tx_data  = data_r;
  assign uart_start_tx = start_r;
  assign grant_id      = grant_r;
  assign busy          = (state_r != IDLE);
  assign timeout_err   = terr_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table-driven single-byte rounds plus
// hand-written sequences for packet locking, timeouts and async reset.
module tb_uart_tx_sched;
  localparam int N     = 4;
  localparam int D     = 5;   // UART model: cycles of start_tx seen before it drops tx_ready
  localparam int FRAME = 4;   // UART model: cycles tx_ready stays low per frame

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic [7:0]       uart_tx_data;
  logic             uart_start_tx;
  logic             uart_tx_ready = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;
  logic             timeout_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } rec_t;
  rec_t tx_log[$];
  int   acc_log[$];

  logic [8:0] qbuf [N][64];
  int         head [N];
  int         tail [N];
  logic [N-1:0] acc = '0;
  bit         uart_dead = 1'b0;
  int         start_high = 0, terr_cnt = 0, busy_nostart = 0, r3_locked = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          n;
    logic [7:0]  eid;
    logic [31:0] ed;
  } vec_t;
  vec_t vecs [6];

  uart_tx_sched #(.N_REQ(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_start_tx (uart_start_tx),
    .uart_tx_ready (uart_tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Requester drivers: present queue heads at negedge, note accepts before the posedge.
  initial begin
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) head[i]++;
      end
      for (int i = 0; i < N; i++) begin
        if (head[i] < tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = qbuf[i][head[i]][7:0];
          req_last[i]        = qbuf[i][head[i]][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #2;
      for (int i = 0; i < N; i++) begin
        acc[i] = rst_n && req_valid[i] && req_ready[i];
        if (acc[i]) acc_log.push_back(i);
      end
    end
  end

  // UART model plus output monitors, evaluated at every negedge.
  initial begin
    int   seen, low_cnt;
    bit   in_frame;
    rec_t r;
    seen = 0; low_cnt = 0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0; in_frame = 1'b0; low_cnt = 0; uart_tx_ready = 1'b1;
      end else if (in_frame) begin
        low_cnt++;
        if (low_cnt >= FRAME) begin
          in_frame = 1'b0;
          uart_tx_ready = 1'b1;
        end
      end else if (uart_start_tx && !uart_dead) begin
        seen++;
        if (seen >= D) begin
          uart_tx_ready = 1'b0;
          in_frame = 1'b1;
          low_cnt = 0;
          seen = 0;
          r.id = grant_id;
          r.data = uart_tx_data;
          tx_log.push_back(r);
        end
      end else begin
        seen = 0;
      end
      if (uart_start_tx) start_high++;
      if (timeout_err) terr_cnt++;
      if (busy && !uart_start_tx) busy_nostart++;
      if (busy && grant_id == 2'd1 && req_ready[3]) r3_locked++;
    end
  end

  // Absolute guard in case something stalls outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    qbuf[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  function automatic bit q_empty();
    for (int i = 0; i < N; i++) begin
      if (head[i] != tail[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clear_mon();
    tx_log.delete();
    acc_log.delete();
    start_high = 0; terr_cnt = 0; busy_nostart = 0; r3_locked = 0;
  endtask

  task automatic wait_done(input int n, input string name);
    int cyc;
    cyc = 0;
    while (!((tx_log.size() >= n) && !busy && q_empty()) && cyc < 600) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    checks++;
    if (cyc >= 600) begin
      failures++;
      $display("FAIL %s: timed out after %0d cycles, log=%0d expected %0d", name, cyc, tx_log.size(), n);
    end
  endtask

  task automatic check_log(input string name, input int k, input logic [1:0] id, input logic [7:0] d);
    if (k < tx_log.size()) begin
      check($sformatf("%s_id%0d", name, k), 32'(tx_log[k].id), 32'(id));
      check($sformatf("%s_data%0d", name, k), 32'(tx_log[k].data), 32'(d));
    end else begin
      check($sformatf("%s_missing%0d", name, k), 32'(tx_log.size()), 32'(k + 1));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_start"}, 32'(uart_start_tx), 32'd0);
    check({name, "_busy"},  32'(busy),          32'd0);
    check({name, "_ready"}, 32'(req_ready),     32'd0);
    check({name, "_data"},  32'(uart_tx_data),  32'd0);
    check({name, "_grant"}, 32'(grant_id),      32'd0);
    check({name, "_terr"},  32'(timeout_err),   32'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    int cyc;
    // Rounds of single-byte requests; pointer carries over between rows.
    vecs[0] = '{mask: 4'b0101, data: 32'h0012_0010, n: 2, eid: 8'h08, ed: 32'h0000_1210};
    vecs[1] = '{mask: 4'b0101, data: 32'h0022_0020, n: 2, eid: 8'h08, ed: 32'h0000_2220};
    vecs[2] = '{mask: 4'b0001, data: 32'h0000_00A5, n: 1, eid: 8'h00, ed: 32'h0000_00A5};
    vecs[3] = '{mask: 4'b1111, data: 32'hB3B2_B1B0, n: 4, eid: 8'h39, ed: 32'hB0B3_B2B1};
    vecs[4] = '{mask: 4'b1001, data: 32'hC300_00C0, n: 2, eid: 8'h03, ed: 32'h0000_C0C3};
    vecs[5] = '{mask: 4'b0001, data: 32'h0000_00D0, n: 1, eid: 8'h00, ed: 32'h0000_00D0};

    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Table-driven rounds
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      for (int r = 0; r < N; r++) begin
        if (vecs[v].mask[r]) push(r, 1'b1, vecs[v].data[r*8 +: 8]);
      end
      wait_done(vecs[v].n, $sformatf("vec%0d_done", v));
      check($sformatf("vec%0d_count", v), 32'(tx_log.size()), 32'(vecs[v].n));
      for (int k = 0; k < vecs[v].n; k++) begin
        check_log($sformatf("vec%0d", v), k, vecs[v].eid[k*2 +: 2], vecs[v].ed[k*8 +: 8]);
      end
      check($sformatf("vec%0d_start_cycles", v), 32'(start_high), 32'(vecs[v].n * (D + 2)));
      check($sformatf("vec%0d_terr", v), 32'(terr_cnt), 32'd0);
      check($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vecs[v].eid[(vecs[v].n - 1)*2 +: 2]));
    end

    // Packet lock: requester 1 sends three bytes while requester 3 waits.
    clear_mon();
    push(1, 1'b0, 8'h11);
    push(1, 1'b0, 8'h22);
    push(1, 1'b1, 8'h33);
    push(3, 1'b1, 8'h44);
    wait_done(4, "lock_done");
    check_log("lock", 0, 2'd1, 8'h11);
    check_log("lock", 1, 2'd1, 8'h22);
    check_log("lock", 2, 2'd1, 8'h33);
    check_log("lock", 3, 2'd3, 8'h44);
    check("lock_accept_order", 32'(acc_log.size() == 4 ? {acc_log[0][7:0], acc_log[1][7:0], acc_log[2][7:0], acc_log[3][7:0]} : 32'hFFFF_FFFF), 32'h0101_0103);
    check("lock_ready3_while_locked", 32'(r3_locked), 32'd0);
    check("lock_terr", 32'(terr_cnt), 32'd0);

    // Launch timeout: UART never takes the byte from requester 0.
    clear_mon();
    uart_dead = 1'b1;
    push(0, 1'b1, 8'h5A);
    push(1, 1'b1, 8'h6B);
    cyc = 0;
    while (!timeout_err && cyc < 100) begin
      tick();
      cyc++;
    end
    uart_dead = 1'b0;
    check("launch_tmo_seen", 32'(timeout_err), 32'd1);
    check("launch_tmo_start_cycles", 32'(start_high), 32'd8);
    check("launch_tmo_start_low", 32'(uart_start_tx), 32'd0);
    wait_done(1, "launch_tmo_done");
    check("launch_tmo_count", 32'(tx_log.size()), 32'd1);
    check_log("launch_tmo", 0, 2'd1, 8'h6B);
    check("launch_tmo_pulses", 32'(terr_cnt), 32'd1);

    // Lock timeout: requester 0 sends a non-last byte then goes silent.
    clear_mon();
    push(0, 1'b0, 8'h77);
    cyc = 0;
    while (tx_log.size() < 1 && cyc < 100) begin
      tick();
      cyc++;
    end
    push(2, 1'b1, 8'h88);
    cyc = 0;
    while (!timeout_err && cyc < 100) begin
      tick();
      cyc++;
    end
    check("lock_tmo_seen", 32'(timeout_err), 32'd1);
    check("lock_tmo_wait_cycles", 32'(busy_nostart), 32'd12);
    wait_done(2, "lock_tmo_done");
    check_log("lock_tmo", 0, 2'd0, 8'h77);
    check_log("lock_tmo", 1, 2'd2, 8'h88);
    check("lock_tmo_pulses", 32'(terr_cnt), 32'd1);

    // Asynchronous reset in the middle of LAUNCH.
    clear_mon();
    push(3, 1'b1, 8'hF3);
    push(2, 1'b1, 8'hE2);
    cyc = 0;
    while (!uart_start_tx && cyc < 20) begin
      tick();
      cyc++;
    end
    check("midrst_pre_busy", 32'(busy), 32'd1);
    check("midrst_pre_grant", 32'(grant_id), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    push(0, 1'b1, 8'hE0);
    repeat (3) tick();
    clear_mon();
    rst_n = 1'b1;
    wait_done(2, "midrst_done");
    check_log("midrst", 0, 2'd0, 8'hE0);
    check_log("midrst", 1, 2'd2, 8'hE2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
